ps2_host_tx: RTL

- Host-to-device PS/2 transmitter; the transmit counterpart of the PS/2 keyboard receive path.
- Sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable.
- Sits beside the receive driver on the shared PS2_CLK/PS2_DAT open-collector lines, in the CLOCK_50 domain.
- Generates the request-to-send sequence, shifts data/parity/stop on device clock edges, and checks the device's line acknowledge.

---
 rtl/ps2_host_tx.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send, frame shifting on device
// clock falls, line-ack check and timeout. Optional line glitch filter: PS2_GLITCH_FILTER_EN.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 1000000
`ifdef PS2_GLITCH_FILTER_EN
  ,
  parameter int FILTER_CYCLES  = 8
`endif
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_dat_drive_low,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic [1:0] error_code
);

  // state    | meaning
  // IDLE     | lines released, ready for a command
  // INHIBIT  | clock held low for INHIBIT_CYCLES
  // REQ      | clock and data low (start bit), one cycle
  // SHIFT    | drive frame bits on device clock falls 1..10
  // WAIT_ACK | sample device ack on fall 11
  // RELEASE  | wait for both lines idle-high
  // DONE     | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_WAIT_ACK, S_RELEASE, S_DONE
  } state_t;

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_NO_ACK  = 2'd2;

  state_t             state_q, state_d;
  logic [9:0]         frame_q, frame_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [INH_W-1:0]   inh_cnt_q, inh_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               dat_low_q, dat_low_d;
  logic               ack_ok_q, ack_ok_d;
  logic [1:0]         err_q, err_d;

  logic clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
  logic clk_prev_q, fall_q;
  logic clk_use, dat_use;
  logic in_timed, tmo_hit;

  // Synchronizer and edge history reset to the idle-high line level.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      clk_meta_q <= ps2_clk_in;
      clk_sync_q <= clk_meta_q;
      dat_meta_q <= ps2_dat_in;
      dat_sync_q <= dat_meta_q;
      clk_prev_q <= clk_use;
      fall_q     <= clk_prev_q & ~clk_use;
    end
  end

`ifdef PS2_GLITCH_FILTER_EN
  localparam int FLT_W = $clog2(FILTER_CYCLES + 1);

  logic [FLT_W-1:0] clk_flt_cnt_q, dat_flt_cnt_q;
  logic             clk_flt_q, dat_flt_q;

  // Output follows the input only after FILTER_CYCLES consecutive differing samples.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_flt_q     <= 1'b1;
      dat_flt_q     <= 1'b1;
      clk_flt_cnt_q <= '0;
      dat_flt_cnt_q <= '0;
    end else begin
      if (clk_sync_q == clk_flt_q) begin
        clk_flt_cnt_q <= '0;
      end else if (clk_flt_cnt_q == FLT_W'(FILTER_CYCLES - 1)) begin
        clk_flt_q     <= clk_sync_q;
        clk_flt_cnt_q <= '0;
      end else begin
        clk_flt_cnt_q <= clk_flt_cnt_q + 1'b1;
      end
      if (dat_sync_q == dat_flt_q) begin
        dat_flt_cnt_q <= '0;
      end else if (dat_flt_cnt_q == FLT_W'(FILTER_CYCLES - 1)) begin
        dat_flt_q     <= dat_sync_q;
        dat_flt_cnt_q <= '0;
      end else begin
        dat_flt_cnt_q <= dat_flt_cnt_q + 1'b1;
      end
    end
  end

  assign clk_use = clk_flt_q;
  assign dat_use = dat_flt_q;
`else
  assign clk_use = clk_sync_q;
  assign dat_use = dat_sync_q;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= S_IDLE;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      tmo_cnt_q <= '0;
      dat_low_q <= 1'b0;
      ack_ok_q  <= 1'b0;
      err_q     <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_cnt_q <= bit_cnt_d;
      inh_cnt_q <= inh_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      dat_low_q <= dat_low_d;
      ack_ok_q  <= ack_ok_d;
      err_q     <= err_d;
    end
  end

  assign in_timed = (state_q == S_SHIFT) || (state_q == S_WAIT_ACK) || (state_q == S_RELEASE);
  assign tmo_hit  = in_timed && (tmo_cnt_q == '0);

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    dat_low_d = dat_low_q;
    ack_ok_d  = ack_ok_q;
    err_d     = err_q;

    if (in_timed) begin
      tmo_cnt_d = tmo_cnt_q - 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        dat_low_d = 1'b0;
        if (cmd_valid) begin
          frame_d   = {1'b1, ~^cmd_data, cmd_data};
          bit_cnt_d = '0;
          inh_cnt_d = INH_W'(INHIBIT_CYCLES - 1);
          ack_ok_d  = 1'b0;
          err_d     = ERR_NONE;
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (inh_cnt_q == '0) begin
          dat_low_d = 1'b1;
          state_d   = S_REQ;
        end else begin
          inh_cnt_d = inh_cnt_q - 1'b1;
        end
      end
      S_REQ: begin
        tmo_cnt_d = TMO_W'(TIMEOUT_CYCLES - 1);
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        if (fall_q) begin
          dat_low_d = ~frame_q[0];
          frame_d   = {1'b0, frame_q[9:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 4'd9) begin
            state_d = S_WAIT_ACK;
          end
        end
      end
      S_WAIT_ACK: begin
        dat_low_d = 1'b0;
        if (fall_q) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (!dat_use) begin
            ack_ok_d = 1'b1;
          end else begin
            err_d = ERR_NO_ACK;
          end
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        dat_low_d = 1'b0;
        if (clk_use && dat_use) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        dat_low_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase

    // Timeout wins over any edge seen in the same cycle.
    if (tmo_hit) begin
      dat_low_d = 1'b0;
      ack_ok_d  = 1'b0;
      err_d     = ERR_TIMEOUT;
      bit_cnt_d = bit_cnt_q;
      frame_d   = frame_q;
      state_d   = S_DONE;
    end
  end

  assign cmd_ready         = (state_q == S_IDLE);
  assign busy              = (state_q != S_IDLE);
  assign done              = (state_q == S_DONE);
  assign ps2_clk_drive_low = (state_q == S_INHIBIT) || (state_q == S_REQ);
  assign ps2_dat_drive_low = dat_low_q;
  assign ack_ok            = ack_ok_q;
  assign error_code        = err_q;

endmodule
